nor_arbiter: RTL

NOR_ARBITER -- requirements
Module: nor_arbiter

---
 rtl/nor_arb_pkg.sv | 18 +
 rtl/nor_struct.sv | 14 +
 rtl/nor_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/nor_arb_pkg.sv
// Shared types and defaults for the round-robin NOR arbiter.
// The FSM state encoding is kept as plain constants for legacy compatibility.
package nor_arb_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned CW_DEF   = 8;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t BUSY = 1'b1;

  // True when at most one bit of a grant vector is set.
  function automatic logic grant_ok(input logic [31:0] vec);
    return (vec & (vec - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/nor_struct.sv
// Two-input NOR datapath shared by all arbiter requesters.
// Built as an explicit OR stage followed by an inverter.
module nor_struct (
  input  logic a,
  input  logic b,
  output logic y
);

  logic or_ab;

  assign or_ab = a | b;
  assign y     = ~or_ab;

endmodule

// File: rtl/nor_arbiter.sv
// Round-robin arbiter time-sharing one NOR datapath among NREQ requesters.
// Each operation takes a grant cycle (IDLE->BUSY) and a compute cycle (BUSY->IDLE).
module nor_arbiter
  import nor_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          a,
  input  logic [NREQ-1:0]          b,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     vld,
  output logic                     res,
  output logic [$clog2(NREQ)-1:0]  id,
  output logic [CW-1:0]            cnt
);

  localparam int unsigned IW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            a_q, a_d;
  logic            b_q, b_d;
  logic [IW-1:0]   id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            vld_q, vld_d;
  logic            res_q, res_d;
  logic [IW-1:0]   res_id_q, res_id_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            nor_y;

  // Search ptr, ptr+1, ... wrapping; IW-bit addition wraps since NREQ is a power of two.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ptr_q + IW'(i);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  nor_struct u_nor (
    .a (a_q),
    .b (b_q),
    .y (nor_y)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    gnt_d    = gnt_q;
    vld_d    = 1'b0;
    res_d    = res_q;
    res_id_d = res_id_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          a_d     = a[win_idx];
          b_d     = b[win_idx];
          id_d    = win_idx;
          gnt_d   = NREQ'(1) << win_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d    = nor_y;
        vld_d    = 1'b1;
        res_id_d = id_q;
        gnt_d    = '0;
        ptr_d    = id_q + IW'(1);
        cnt_d    = cnt_q + CW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      id_q     <= '0;
      gnt_q    <= '0;
      vld_q    <= 1'b0;
      res_q    <= 1'b0;
      res_id_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      gnt_q    <= gnt_d;
      vld_q    <= vld_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == BUSY);
  assign vld  = vld_q;
  assign res  = res_q;
  assign id   = res_id_q;
  assign cnt  = cnt_q;

  gnt_onehot: assert property (@(posedge clk) disable iff (rst) grant_ok(32'(gnt_q)));

endmodule
